// File: rtl/fifo_unpack_pkg.sv
// Shared definitions for the wide-to-narrow FIFO unpacker: holding-register
// states and lane-count helpers.
package fifo_unpack_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Bits needed to index 'r' lanes; never less than one.
  function automatic int unsigned lane_bits(input int unsigned r);
    int unsigned b;
    b = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < r) b = i + 1;
    end
    return (b == 0) ? 1 : b;
  endfunction

  function automatic bit is_pow2(input int unsigned r);
    return (r >= 2) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/unpack_lane_sel.sv
// Lane multiplexer: selects narrow lane idx_i of the held wide word, lane 0 in the LSBs.
module unpack_lane_sel #(
  parameter int iwidth = 128,
  parameter int owidth = 32,
  parameter int idxw   = 2
) (
  input  logic [iwidth-1:0] hreg_i,
  input  logic [idxw-1:0]   idx_i,
  output logic [owidth-1:0] d_out_o
);

  always_comb begin
    d_out_o = hreg_i[idx_i*owidth +: owidth];
  end

endmodule

// File: rtl/fifo_unpack.sv
// Splits each wide upstream FIFO word into ratio narrow lanes for a downstream FIFO.
// Define FIFO_UNPACK_COUNT_EN to compile in the WCOUNT emitted-word counter.
module fifo_unpack
  import fifo_unpack_pkg::*;
#(
  parameter int iwidth = 128,
  parameter int owidth = 32,
  localparam int ratio = iwidth / owidth
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              EMPTY_N_I,
  input  logic [iwidth-1:0] D_IN,
  output logic              DEQ,
  input  logic              FULL_N_I,
  output logic              ENQ,
  output logic [owidth-1:0] D_OUT,
  output logic [31:0]       WCOUNT
);

  localparam int IDXW = lane_bits(ratio);

  if ((iwidth % owidth) != 0 || !is_pow2(ratio)) begin : g_bad_cfg
    $error("fifo_unpack: iwidth must be owidth times a power of two >= 2");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [iwidth-1:0] hreg_q, hreg_d;
  logic              hvalid, last_lane, enq, deq;

  assign hvalid    = (state_q == HOLD);
  assign last_lane = (idx_q == IDXW'(ratio - 1));
  assign enq       = hvalid && FULL_N_I && !CLR;
  // RST gates DEQ so an asserted reset never pops a word it would then drop.
  assign deq       = EMPTY_N_I && !RST && !CLR && (!hvalid || (enq && last_lane));
  assign ENQ       = enq;
  assign DEQ       = deq;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hreg_d  = hreg_q;
    if (CLR) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (deq) begin
      state_d = HOLD;
      idx_d   = '0;
      hreg_d  = D_IN;
    end else if (enq) begin
      if (last_lane) begin
        state_d = EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge CLK) begin
    hreg_q <= hreg_d;
  end

  unpack_lane_sel #(
    .iwidth (iwidth),
    .owidth (owidth),
    .idxw   (IDXW)
  ) u_lane_sel (
    .hreg_i  (hreg_q),
    .idx_i   (idx_q),
    .d_out_o (D_OUT)
  );

`ifdef FIFO_UNPACK_COUNT_EN
  logic [31:0] wcount_q, wcount_d;

  always_comb begin
    wcount_d = wcount_q;
    if (CLR)      wcount_d = '0;
    else if (enq) wcount_d = wcount_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) wcount_q <= '0;
    else     wcount_q <= wcount_d;
  end

  assign WCOUNT = wcount_q;
`else
  assign WCOUNT = '0;
`endif

endmodule

// File: tb/tb_fifo_unpack.sv
// Bench for fifo_unpack: queue-based lane model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_fifo_unpack;

  localparam int IW = 128;
  localparam int OW = 32;
  localparam int R  = IW / OW;

  logic          CLK = 1'b0;
  logic          RST, CLR, EMPTY_N_I, FULL_N_I;
  logic [IW-1:0] D_IN;
  logic          DEQ, ENQ;
  logic [OW-1:0] D_OUT;
  logic [31:0]   WCOUNT;

  fifo_unpack #(.iwidth(IW), .owidth(OW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (CLR),
    .EMPTY_N_I (EMPTY_N_I),
    .D_IN      (D_IN),
    .DEQ       (DEQ),
    .FULL_N_I  (FULL_N_I),
    .ENQ       (ENQ),
    .D_OUT     (D_OUT),
    .WCOUNT    (WCOUNT)
  );

  always #5 CLK = ~CLK;

  logic [IW-1:0] up_q[$];
  logic [OW-1:0] lanes[$];
  logic [31:0]   cnt;
  int            checks = 0;
  int            errors = 0;
  logic          last_enq, last_deq;
  logic [OW-1:0] last_dout;
  logic [31:0]   last_wcount;

  localparam logic [IW-1:0] W0 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [IW-1:0] W1 = 128'h88888888_77777777_66666666_55555555;

`ifdef FIFO_UNPACK_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive upstream/downstream, compare DUT to the lane model, advance the model.
  task automatic step(input bit up_en, input bit fn, input bit clr);
    logic          exp_enq, exp_deq;
    logic [IW-1:0] w;
    @(negedge CLK);
    FULL_N_I  = fn;
    CLR       = clr;
    EMPTY_N_I = up_en && (up_q.size() > 0);
    D_IN      = (up_q.size() > 0) ? up_q[0] : '0;
    #1;
    exp_enq = (lanes.size() > 0) && fn && !clr;
    exp_deq = EMPTY_N_I && !clr && ((lanes.size() == 0) || (exp_enq && lanes.size() == 1));
    chk("ENQ", ENQ, exp_enq);
    chk("DEQ", DEQ, exp_deq);
    if (lanes.size() > 0) chk("D_OUT", D_OUT, lanes[0]);
    chk("WCOUNT", WCOUNT, CNT_ON ? cnt : 32'd0);
    last_enq    = ENQ;
    last_deq    = DEQ;
    last_dout   = D_OUT;
    last_wcount = WCOUNT;
    @(posedge CLK);
    if (clr) begin
      lanes.delete();
      cnt = '0;
    end else begin
      if (exp_enq) begin
        void'(lanes.pop_front());
        cnt = cnt + 32'd1;
      end
      if (exp_deq) begin
        w = up_q.pop_front();
        for (int unsigned k = 0; k < R; k++) lanes.push_back(w[k*OW +: OW]);
      end
    end
  endtask

  // Asynchronous reset pulse between clock edges while lane 1 is presented.
  task automatic rst_pulse();
    @(negedge CLK);
    FULL_N_I  = 1'b1;
    CLR       = 1'b0;
    EMPTY_N_I = 1'b0;
    #1;
    chk("rst_pre_enq", ENQ, 1'b1);
    chk("rst_pre_dout", D_OUT, 32'h22222222);
    RST = 1'b1;
    #1;
    chk("rst_enq", ENQ, 1'b0);
    chk("rst_deq", DEQ, 1'b0);
    chk("rst_wcount", WCOUNT, 32'd0);
    #1;
    RST = 1'b0;
    lanes.delete();
    cnt = '0;
    @(posedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] lit[4];
    lit = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    cnt = '0;
    RST = 1'b1; CLR = 1'b0; EMPTY_N_I = 1'b1; FULL_N_I = 1'b1; D_IN = W0;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_enq", ENQ, 1'b0);
    chk("reset_deq", DEQ, 1'b0);
    chk("reset_wcount", WCOUNT, 32'd0);
    EMPTY_N_I = 1'b0;
    RST = 1'b0;

    // Single word, free-flowing downstream.
    up_q.push_back(W0);
    step(1, 1, 0);
    chk("w1_deq", last_deq, 1'b1);
    chk("w1_lat_enq", last_enq, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0);
      chk("w1_enq", last_enq, 1'b1);
      chk("w1_lane", last_dout, lit[i]);
      chk("w1_nodeq", last_deq, 1'b0);
    end
    step(1, 1, 0);
    chk("w1_done", last_enq, 1'b0);

    // Backpressure after lane 1.
    up_q.push_back(W0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("bp_lane0", last_dout, 32'h11111111);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      chk("bp_enq", last_enq, 1'b0);
      chk("bp_deq", last_deq, 1'b0);
      chk("bp_hold", last_dout, 32'h22222222);
    end
    for (int i = 1; i < 4; i++) begin
      step(1, 1, 0);
      chk("bp_resume", last_dout, lit[i]);
    end

    // CLR while lane 2 is presented.
    up_q.push_back(W0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    chk("clr_enq", last_enq, 1'b0);
    chk("clr_deq", last_deq, 1'b0);
    chk("clr_dout", last_dout, 32'h33333333);
    up_q.push_back(W1);
    step(1, 1, 0);
    chk("clr_after_enq", last_enq, 1'b0);
    chk("clr_after_deq", last_deq, 1'b1);
    chk("clr_wcount", last_wcount, 32'd0);
    step(1, 1, 0);
    chk("clr_new_lane0", last_dout, 32'h55555555);
    repeat (3) step(1, 1, 0);

    // Three words back-to-back, counter started from a clear.
    step(0, 1, 1);
    up_q.push_back(W0); up_q.push_back(W1); up_q.push_back(W0);
    for (int c = 0; c < 13; c++) begin
      step(1, 1, 0);
      chk("b2b_deq", last_deq, (c == 0 || c == 4 || c == 8) ? 1'b1 : 1'b0);
      chk("b2b_enq", last_enq, (c >= 1) ? 1'b1 : 1'b0);
    end
    step(1, 1, 0);
    chk("b2b_idle", last_enq, 1'b0);
    chk("b2b_wcount", last_wcount, CNT_ON ? 32'd12 : 32'd0);

    // Async reset mid-word.
    up_q.push_back(W0);
    step(1, 1, 0);
    step(1, 1, 0);
    rst_pulse();
    step(1, 1, 0);
    chk("post_rst_enq", last_enq, 1'b0);
    chk("post_rst_deq", last_deq, 1'b0);

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 800; n++) begin
      if (up_q.size() < 3 && $urandom_range(0, 1) == 1)
        up_q.push_back({$urandom, $urandom, $urandom, $urandom});
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
